// File: rtl/clk_div_if.sv
// Bus bundle for the multi-channel clock divider.
// With CLK_DIV_TICK_EN defined, the bundle carries the per-channel tick strobe.
interface clk_div_if #(
  parameter int NCH = 4,
  parameter int CW  = 8
);
  logic [NCH-1:0]         en;
  logic [NCH-1:0]         ld;
  logic [NCH-1:0][CW-1:0] half_per;
  logic [NCH-1:0]         clk_out;
  logic [NCH-1:0]         run;
`ifdef CLK_DIV_TICK_EN
  logic [NCH-1:0]         tick;
  modport master (output en, ld, half_per, input clk_out, run, tick);
  modport slave  (input en, ld, half_per, output clk_out, run, tick);
`else
  modport master (output en, ld, half_per, input clk_out, run);
  modport slave  (input en, ld, half_per, output clk_out, run);
`endif
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel 50%-duty clock divider with glitch-free start/stop and shadowed ratio.
// Optional CLK_DIV_TICK_EN adds a one-cycle tick at each rising edge of clk_out.
module clk_div_ch #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] hp,
  output logic          clk_out,
`ifdef CLK_DIV_TICK_EN
  output logic          tick,
`endif
  output logic          run
);
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, STOP} st_t;
  st_t           st;
  logic [CW-1:0] cnt, active, pending, hp_w, nxt_pend;

  assign hp_w     = (hp == '0) ? ONE : hp;
  assign nxt_pend = ld ? hp_w : pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      clk_out <= 1'b0;
      run     <= 1'b0;
      cnt     <= '0;
      active  <= ONE;
      pending <= ONE;
`ifdef CLK_DIV_TICK_EN
      tick    <= 1'b0;
`endif
    end else begin
      pending <= nxt_pend;
`ifdef CLK_DIV_TICK_EN
      tick    <= 1'b0;
`endif
      case (st)
        IDLE: if (en) begin
          // same-cycle ld bypasses the shadow register
          st     <= RUN;
          run    <= 1'b1;
          active <= nxt_pend;
          cnt    <= nxt_pend - ONE;
        end
        RUN, STOP: begin
          if (st == RUN && !en && !clk_out) begin
            st  <= IDLE;
            run <= 1'b0;
            cnt <= '0;
          end else begin
            if (st == RUN && !en) st <= STOP;
            if (cnt == '0) begin
              clk_out <= ~clk_out;
              if (clk_out) begin
                // period boundary: adopt the shadowed half-period before reload
                active <= pending;
                cnt    <= pending - ONE;
                if (st == STOP || !en) begin
                  st  <= IDLE;
                  run <= 1'b0;
                  cnt <= '0;
                end
              end else begin
                cnt <= active - ONE;
`ifdef CLK_DIV_TICK_EN
                tick <= 1'b1;
`endif
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module clk_div_gen #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input logic      clk,
  input logic      rst,
  clk_div_if.slave bus
);
  logic [NCH-1:0] co, rn;
`ifdef CLK_DIV_TICK_EN
  logic [NCH-1:0] tk;
  assign bus.tick = tk;
`endif
  assign bus.clk_out = co;
  assign bus.run     = rn;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(.CW(CW)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en[i]),
      .ld      (bus.ld[i]),
      .hp      (bus.half_per[i]),
      .clk_out (co[i]),
`ifdef CLK_DIV_TICK_EN
      .tick    (tk[i]),
`endif
      .run     (rn[i])
    );
  end
endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: expected clk_out/run/tick per edge are queued
// at stimulus time and compared on the falling clock edge.
module tb_clk_div_gen;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  clk_div_if #(.NCH(NCH), .CW(CW)) bus ();
  clk_div_gen #(.NCH(NCH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    ch;
    bit    c;
    bit    r;
    bit    t;
    string tag;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input bit co, input bit rn, input bit tk,
                      input string tag);
    exp_t e;
    e.cyc = c; e.ch = ch; e.c = co; e.r = rn; e.t = tk; e.tag = tag;
    sb.push_back(e);
  endtask

  // free-running wave from an en edge e0 with fixed half-period a
  task automatic exp_wave(input int ch, input int e0, input int a, input int n, input string tag);
    for (int k = 0; k <= n; k++)
      push(e0 + k, ch, ((k / a) % 2) == 1, 1'b1, (k % a == 0) && ((k / a) % 2 == 1),
           $sformatf("%s%0d_k%0d", tag, ch, k));
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk({sb[i].tag, "_clk"}, 32'(bus.clk_out[sb[i].ch]), 32'(sb[i].c));
        chk({sb[i].tag, "_run"}, 32'(bus.run[sb[i].ch]), 32'(sb[i].r));
`ifdef CLK_DIV_TICK_EN
        chk({sb[i].tag, "_tick"}, 32'(bus.tick[sb[i].ch]), 32'(sb[i].t));
`endif
        sb.delete(i);
      end
    end
  end

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1; bus.en = '0; bus.ld = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int e0;

  initial begin
    rst = 1'b1;
    bus.en = '1; bus.ld = '0; bus.half_per = '0;

    // reset held two edges with en high, then default half-period 1
    for (int ch = 0; ch < NCH; ch++) begin
      push(1, ch, 1'b0, 1'b0, 1'b0, $sformatf("rst%0d_e1", ch));
      push(2, ch, 1'b0, 1'b0, 1'b0, $sformatf("rst%0d_e2", ch));
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    e0 = cyc + 1;
    for (int ch = 0; ch < NCH; ch++) exp_wave(ch, e0, 1, 8, "dflt");
    repeat (9) @(negedge clk);

    // ld in IDLE then start; plus same-edge bypass and half_per=0
    do_rst();
    bus.ld[0] = 1'b1; bus.half_per[0] = 8'd3;
    push(cyc + 1, 0, 1'b0, 1'b0, 1'b0, "ld_idle0");
    @(negedge clk);
    bus.ld = '0;
    e0 = cyc + 1;
    bus.en = 4'b1011;
    bus.ld[1] = 1'b1; bus.half_per[1] = 8'd0;
    bus.ld[3] = 1'b1; bus.half_per[3] = 8'd2;
    exp_wave(0, e0, 3, 14, "hp3_");
    exp_wave(1, e0, 1, 10, "hp0_");
    exp_wave(3, e0, 2, 10, "byp");
    @(negedge clk);
    bus.ld = '0;
    repeat (15) @(negedge clk);

    // shadowed update: ch1 mid-high, ch2 on a falling boundary edge
    do_rst();
    e0 = cyc + 1;
    bus.ld = 4'b0110; bus.en = 4'b0110;
    bus.half_per[1] = 8'd2; bus.half_per[2] = 8'd3;
    for (int k = 0; k <= 20; k++) begin
      bit c1, t1, c2, t2;
      c1 = (k < 4) ? ((k / 2) % 2 == 1) : (((k - 4) / 5) % 2 == 1);
      t1 = (k == 2) || (k == 9) || (k == 19);
      c2 = (k < 12) ? ((k / 3) % 2 == 1) : ((k - 12) % 2 == 1);
      t2 = (k == 3) || (k == 9) || (k > 12 && (k % 2 == 1));
      push(e0 + k, 1, c1, 1'b1, t1, $sformatf("shd1_k%0d", k));
      push(e0 + k, 2, c2, 1'b1, t2, $sformatf("bnd2_k%0d", k));
    end
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      bus.ld = '0;
      if (k == 2) begin bus.ld[1] = 1'b1; bus.half_per[1] = 8'd5; end
      if (k == 5) begin bus.ld[2] = 1'b1; bus.half_per[2] = 8'd1; end
    end

    // stop in high phase (STOP, en re-asserted ignored), restart, stop in low phase
    do_rst();
    e0 = cyc + 1;
    bus.ld[2] = 1'b1; bus.half_per[2] = 8'd4; bus.en[2] = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      bit c, r;
      c = (k >= 4 && k <= 7) || (k >= 13 && k <= 16);
      r = !(k == 8 || k >= 18);
      push(e0 + k, 2, c, r, (k == 4) || (k == 13), $sformatf("stp2_k%0d", k));
    end
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      bus.ld = '0;
      if (k == 4)  bus.en[2] = 1'b0;
      if (k == 5)  bus.en[2] = 1'b1;
      if (k == 17) bus.en[2] = 1'b0;
    end

    // reset pulsed mid high phase on every channel; restart uses half-period 1
    do_rst();
    e0 = cyc + 1;
    bus.ld = '1; bus.en = '1;
    for (int ch = 0; ch < NCH; ch++) begin
      bus.half_per[ch] = 8'd3;
      for (int k = 0; k <= 3; k++)
        push(e0 + k, ch, k == 3, 1'b1, k == 3, $sformatf("pre%0d_k%0d", ch, k));
      push(e0 + 4, ch, 1'b0, 1'b0, 1'b0, $sformatf("mrst%0d", ch));
      exp_wave(ch, e0 + 5, 1, 6, "post");
    end
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      bus.ld = '0;
      rst = (k == 3);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
